// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide RAM port between the instruction
// fetcher (word reads) and the LSU (byte/half/word loads and stores).
// One requester is granted at a time from IDLE. Bytes are moved serially and
// assembled or split little-endian.
// Optional feature macro: STARVE_GUARD_EN. When it is defined, the fetcher is
// guaranteed a grant after STARVE_LIMIT back-to-back LSU grants. When it is
// undefined, the LSU has strict priority.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              lsu_req,
  input  logic              lsu_wr,
  input  logic [1:0]        lsu_size,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [1:0]  last_idx;
  logic [31:0] rd_buf;
  logic [31:0] wr_buf;
  logic [31:0] assembled;
  logic        can_grant;
  logic        grant_if;
  logic        grant_ls;
  logic        starve_hit;

  // Index of the last byte for an LSU access size. Sizes 10 and 11 are both words.
  function automatic logic [1:0] last_of(input logic [1:0] size);
    case (size)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Replace byte lane idx of word with b. Lane 0 holds the lowest address.
  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = word;
    r[8*idx +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

  assign assembled = put_byte(rd_buf, byte_cnt, mem_din);

  // Grant decision: only from IDLE, and never while a done pulse is still out.
  always_comb begin
    can_grant = (state == IDLE) && !if_done && !lsu_done;
    grant_if  = can_grant && if_req && !if_flush && (!lsu_req || starve_hit);
    grant_ls  = can_grant && lsu_req && !grant_if;
  end

`ifdef STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));

  // Count LSU grants that overtake a waiting fetch. Saturates at the limit.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      starve_cnt <= '0;
    end else if (rdy_in) begin
      if (grant_if)
        starve_cnt <= '0;
      else if (grant_ls && if_req && !starve_hit)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  // The limit only matters with the guard. It is kept referenced so that both
  // builds share one parameter list.
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT > 0);
  assign starve_hit = 1'b0;
`endif

  // Transfer FSM: grant, byte-serial sequencing, and registered port/result outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      last_idx  <= '0;
      rd_buf    <= '0;
      wr_buf    <= '0;
      mem_a     <= '0;
      mem_wr    <= 1'b0;
      mem_dout  <= '0;
      if_done   <= 1'b0;
      if_inst   <= '0;
      lsu_done  <= 1'b0;
      lsu_rdata <= '0;
    end else if (rdy_in) begin
      if_done  <= 1'b0;
      lsu_done <= 1'b0;
      case (state)
        IDLE: begin
          mem_a    <= '0;
          mem_wr   <= 1'b0;
          mem_dout <= '0;
          if (grant_ls) begin
            state    <= lsu_wr ? LS_WR : LS_RD;
            mem_a    <= lsu_addr;
            mem_wr   <= lsu_wr;
            mem_dout <= lsu_wr ? lsu_wdata[7:0] : 8'h00;
            byte_cnt <= '0;
            last_idx <= last_of(lsu_size);
            rd_buf   <= '0;
            wr_buf   <= lsu_wdata;
          end else if (grant_if) begin
            state    <= IF_RD;
            mem_a    <= if_addr;
            byte_cnt <= '0;
            last_idx <= 2'd3;
            rd_buf   <= '0;
          end
        end
        IF_RD: begin
          if (if_flush) begin
            state <= IDLE;
            mem_a <= '0;
          end else if (byte_cnt == last_idx) begin
            state   <= IDLE;
            mem_a   <= '0;
            if_inst <= assembled;
            if_done <= 1'b1;
          end else begin
            rd_buf   <= assembled;
            mem_a    <= mem_a + ADDR_W'(1);
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        LS_RD: begin
          if (byte_cnt == last_idx) begin
            state     <= IDLE;
            mem_a     <= '0;
            lsu_rdata <= assembled;
            lsu_done  <= 1'b1;
          end else begin
            rd_buf   <= assembled;
            mem_a    <= mem_a + ADDR_W'(1);
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        LS_WR: begin
          if (byte_cnt == last_idx) begin
            state    <= IDLE;
            mem_a    <= '0;
            mem_wr   <= 1'b0;
            mem_dout <= '0;
            lsu_done <= 1'b1;
          end else begin
            mem_a    <= mem_a + ADDR_W'(1);
            mem_dout <= get_byte(wr_buf, byte_cnt + 2'd1);
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It uses table-driven vectors,
// hand-written corner sequences, and randomized transactions.
// Expected results come from a simple RAM-content function and byte arithmetic.
module tb_mem_port_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_inst;
  logic        lsu_req = 1'b0;
  logic        lsu_wr = 1'b0;
  logic [1:0]  lsu_size = 2'b00;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_done;
  logic [31:0] lsu_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_size(lsu_size), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata)
  );

  always #5 clk_in = ~clk_in;

  // Read-only RAM image: a few fixed bytes, and a pattern everywhere else.
  function automatic logic [7:0] ram_val(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0101: return 8'h05;
      32'h0000_0102: return 8'h00;
      32'h0000_0103: return 8'h00;
      32'h0000_0007: return 8'h80;
      32'h0000_0200: return 8'hAA;
      32'h0000_0201: return 8'hBB;
      32'h0000_0202: return 8'hCC;
      32'h0000_0203: return 8'hDD;
      32'hFFFF_FFFE: return 8'h11;
      32'hFFFF_FFFF: return 8'h22;
      32'h0000_0000: return 8'h33;
      32'h0000_0001: return 8'h44;
      default:       return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  assign mem_din = ram_val(mem_a);

  // Write log of every byte the RAM would accept (write enable on a live edge).
  logic [31:0] wl_a [0:255];
  logic [7:0]  wl_d [0:255];
  int          wl_n = 0;

  always @(posedge clk_in) begin
    if (rst_in && rdy_in && mem_wr) begin
      wl_a[wl_n[7:0]] <= mem_a;
      wl_d[wl_n[7:0]] <= mem_dout;
      wl_n <= wl_n + 1;
    end
  end

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Reference model: little-endian load of n bytes starting at addr, zero-extended.
  function automatic logic [31:0] exp_read(input logic [31:0] addr, input int n);
    logic [31:0] r;
    r = 0;
    for (int k = 0; k < n; k++) r = r + (32'(ram_val(addr + 32'(k))) << (8 * k));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Issue one request and wait (bounded) for its done pulse. Optionally drop rdy_in
  // for stall_len edges after sample stall_at. Ends one idle cycle after done.
  task automatic run_txn(input bit is_if, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall_at, input int stall_len,
                         output logic [31:0] data, output int cycles);
    int cyc;
    bit got;
    data = '0; cycles = -1; cyc = 0; got = 0;
    if (is_if) begin
      if_addr = addr; if_req = 1'b1;
    end else begin
      lsu_wr = wr; lsu_size = size; lsu_addr = addr; lsu_wdata = wdata; lsu_req = 1'b1;
    end
    while (!got && cyc < 60) begin
      tick();
      cyc++;
      if (is_if ? if_done : lsu_done) begin
        got = 1; cycles = cyc; data = is_if ? if_inst : lsu_rdata;
      end else begin
        if (stall_len > 0 && cyc == stall_at) rdy_in = 1'b0;
        if (stall_len > 0 && cyc == stall_at + stall_len) rdy_in = 1'b1;
      end
    end
    if_req = 1'b0; lsu_req = 1'b0; rdy_in = 1'b1;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL timeout waiting for done (is_if=%0d addr=0x%08h)", is_if, addr);
    end
    tick();
  endtask

  task automatic do_txn(input string name, input bit is_if, input bit wr,
                        input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall_at, input int stall_len,
                        input logic [31:0] exp_data, input int exp_cycles);
    int start, n, cycles;
    logic [31:0] data;
    logic [7:0] idx;
    n = is_if ? 4 : nbytes(size);
    start = wl_n;
    run_txn(is_if, wr, size, addr, wdata, stall_at, stall_len, data, cycles);
    check({name, " latency"}, 32'(cycles), 32'(exp_cycles));
    if (is_if || !wr) check({name, " data"}, data, exp_data);
    check({name, " write count"}, 32'(wl_n - start), (!is_if && wr) ? 32'(n) : 32'd0);
    if (!is_if && wr) begin
      for (int k = 0; k < n; k++) begin
        idx = 8'(start + k);
        check({name, " write addr"}, wl_a[idx], addr + 32'(k));
        check({name, " write byte"}, 32'(wl_d[idx]), (wdata >> (8 * k)) & 32'hFF);
      end
    end
  endtask

  typedef struct {
    bit          is_if;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall_at;
    int          stall_len;
    logic [31:0] exp_data;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [0:8];

  initial begin
    logic [31:0] prev_inst;
    logic [31:0] exp_d;
    int order [0:7];
    int nd;
    int cyc;
    bit got;

    vecs[0] = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0, 0, 0, 32'h0000_0513, 5};
    vecs[1] = '{1'b0, 1'b0, 2'b10, 32'h0000_0200, 32'h0, 0, 0, 32'hDDCC_BBAA, 5};
    vecs[2] = '{1'b0, 1'b0, 2'b00, 32'h0000_0203, 32'h0, 0, 0, 32'h0000_00DD, 2};
    vecs[3] = '{1'b0, 1'b0, 2'b01, 32'h0000_0201, 32'h0, 0, 0, 32'h0000_CCBB, 3};
    vecs[4] = '{1'b0, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0, 0, 0, 32'h4433_2211, 5};
    vecs[5] = '{1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hCAFE_F00D, 0, 0, 32'h0, 5};
    vecs[6] = '{1'b0, 1'b0, 2'b01, 32'h0000_0201, 32'h0, 2, 3, 32'h0000_CCBB, 6};
    vecs[7] = '{1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'h0, 1, 2, 32'hDDCC_BBAA, 7};
    vecs[8] = '{1'b0, 1'b1, 2'b00, 32'h0000_0030, 32'h1234_5655, 0, 0, 32'h0, 2};

    // Reset state
    #2;
    check("reset mem_a", mem_a, 32'h0);
    check("reset mem_wr", 32'(mem_wr), 32'h0);
    check("reset mem_dout", 32'(mem_dout), 32'h0);
    check("reset if_done", 32'(if_done), 32'h0);
    check("reset lsu_done", 32'(lsu_done), 32'h0);
    check("reset if_inst", if_inst, 32'h0);
    check("reset lsu_rdata", lsu_rdata, 32'h0);
    tick(); tick();
    rst_in = 1'b1;
    tick();

    // Fetch 0x100: address sequence and assembled instruction
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("fetch mem_a", mem_a, 32'h100 + 32'(k));
      check("fetch mem_wr", 32'(mem_wr), 32'h0);
    end
    tick();
    check("fetch if_done", 32'(if_done), 32'h1);
    check("fetch if_inst", if_inst, 32'h0000_0513);
    check("fetch mem_a idle", mem_a, 32'h0);
    if_req = 1'b0;
    tick();
    check("fetch done one cycle", 32'(if_done), 32'h0);

    // Store half 0x1234BEEF at 0x20: per-edge port values
    lsu_wr = 1'b1; lsu_size = 2'b01; lsu_addr = 32'h20; lsu_wdata = 32'h1234_BEEF; lsu_req = 1'b1;
    tick();
    check("st half a0", mem_a, 32'h20);
    check("st half d0", 32'(mem_dout), 32'hEF);
    check("st half wr0", 32'(mem_wr), 32'h1);
    tick();
    check("st half a1", mem_a, 32'h21);
    check("st half d1", 32'(mem_dout), 32'hBE);
    check("st half wr1", 32'(mem_wr), 32'h1);
    tick();
    check("st half done", 32'(lsu_done), 32'h1);
    check("st half wr end", 32'(mem_wr), 32'h0);
    check("st half a end", mem_a, 32'h0);
    check("st half d end", 32'(mem_dout), 32'h0);
    lsu_req = 1'b0;
    tick();

    // Simultaneous requests: LSU first, fetch after the blocked idle cycle
    if_addr = 32'h100; if_req = 1'b1;
    lsu_wr = 1'b0; lsu_size = 2'b00; lsu_addr = 32'h7; lsu_req = 1'b1;
    tick();
    check("both: lsu granted", mem_a, 32'h7);
    tick();
    check("both: lsu_done", 32'(lsu_done), 32'h1);
    check("both: lsu_rdata", lsu_rdata, 32'h0000_0080);
    lsu_req = 1'b0;
    tick();
    check("both: idle after done", mem_a, 32'h0);
    tick();
    check("both: fetch granted", mem_a, 32'h100);
    got = 0; cyc = 0;
    while (!got && cyc < 20) begin
      tick(); cyc++;
      if (if_done) got = 1;
    end
    check("both: fetch completes", 32'(cyc), 32'd4);
    check("both: if_inst", if_inst, 32'h0000_0513);
    if_req = 1'b0;
    tick();

    // Vector table
    for (int i = 0; i < 9; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].is_if, vecs[i].wr, vecs[i].size, vecs[i].addr,
             vecs[i].wdata, vecs[i].stall_at, vecs[i].stall_len, vecs[i].exp_data,
             vecs[i].exp_cycles);

    // Flush mid-fetch, with an LSU request waiting
    prev_inst = if_inst;
    if_addr = 32'h100; if_req = 1'b1;
    tick(); tick();
    if_flush = 1'b1;
    lsu_wr = 1'b0; lsu_size = 2'b00; lsu_addr = 32'h7; lsu_req = 1'b1;
    tick();
    check("flush mem_a", mem_a, 32'h0);
    check("flush no if_done", 32'(if_done), 32'h0);
    if_req = 1'b0; if_flush = 1'b0;
    tick();
    check("flush lsu granted", mem_a, 32'h7);
    tick();
    check("flush lsu_done", 32'(lsu_done), 32'h1);
    check("flush lsu_rdata", lsu_rdata, 32'h0000_0080);
    check("flush if_done stays 0", 32'(if_done), 32'h0);
    check("flush if_inst kept", if_inst, prev_inst);
    lsu_req = 1'b0;
    tick();

    // Randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      bit is_if, wr;
      logic [1:0] size;
      logic [31:0] addr, wdata;
      int n, sa, sl, kind;
      kind = int'($urandom_range(0, 2));
      is_if = (kind == 0);
      wr = (kind == 2);
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      wdata = $urandom;
      n = is_if ? 4 : nbytes(size);
      sa = 0; sl = 0;
      if ($urandom_range(0, 1) == 1) begin
        sa = int'($urandom_range(1, n));
        sl = int'($urandom_range(1, 3));
      end
      exp_d = exp_read(addr, n);
      do_txn($sformatf("rand%0d", i), is_if, wr, size, addr, wdata, sa, sl, exp_d, n + 1 + sl);
    end

    // Asynchronous reset in the middle of a word load
    lsu_wr = 1'b0; lsu_size = 2'b10; lsu_addr = 32'h200; lsu_req = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
    #1;
    check("midrst mem_a", mem_a, 32'h0);
    check("midrst mem_wr", 32'(mem_wr), 32'h0);
    check("midrst lsu_rdata", lsu_rdata, 32'h0);
    check("midrst if_inst", if_inst, 32'h0);
    lsu_req = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    check("midrst after mem_a", mem_a, 32'h0);
    check("midrst after mem_wr", 32'(mem_wr), 32'h0);
    check("midrst no done", 32'(lsu_done), 32'h0);

    // Starvation: both requests held continuously from a fresh reset
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    if_addr = 32'h100; if_req = 1'b1;
    lsu_wr = 1'b0; lsu_size = 2'b00; lsu_addr = 32'h7; lsu_req = 1'b1;
    nd = 0; cyc = 0;
    while (nd < 6 && cyc < 80) begin
      tick(); cyc++;
      if (lsu_done) begin order[nd] = 0; nd++; end
      else if (if_done) begin order[nd] = 1; nd++; end
    end
    check("starve grants seen", 32'(nd), 32'd6);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] e;
`ifdef STARVE_GUARD_EN
      e = (i == 4) ? 32'd1 : 32'd0;
`else
      e = 32'd0;
`endif
      check($sformatf("starve order%0d", i), 32'(order[i]), e);
    end
    if_req = 1'b0; lsu_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
